// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared types and default widths for the framebuffer arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_fb_pkg;

   localparam int FB_ADDR_W = 19;  // SRAM word address width
   localparam int FB_DATA_W = 24;  // 8:8:8 RGB pixel word
   localparam int LB_ADDR_W = 11;  // {bank, index[9:0]}
   localparam int LB_IDX_W  = 10;  // line buffer index width

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH     = 2'd1,
      HOST_SLOT = 2'd2
   } fb_state_e;

endpackage

// File: rtl/vga_fb_rd_pipe.sv
// vga_fb_rd_pipe: turns an issued SRAM read into a line-buffer write one cycle later.
// Latency: 1 cycle from rd_issue to lb_we; lb_wdata is mem_rdata passed straight through.
// Backpressure: none; runs independently of the arbiter FSM so in-flight reads always land.
// Ports: clk/rst; rd_issue/rd_bank/rd_idx describe the read issued this cycle;
//        mem_rdata is the SRAM return; lb_we/lb_addr/lb_wdata drive the line buffer.
module vga_fb_rd_pipe
   import vga_fb_pkg::*;
#(
   parameter int DATA_W = FB_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_issue,
   input  logic                 rd_bank,
   input  logic [LB_IDX_W-1:0]  rd_idx,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 lb_we,
   output logic [LB_ADDR_W-1:0] lb_addr,
   output logic [DATA_W-1:0]    lb_wdata
);

   logic                valid_q, valid_d;
   logic                bank_q,  bank_d;
   logic [LB_IDX_W-1:0] idx_q,   idx_d;

   always_comb begin
      valid_d = rd_issue;
      bank_d  = rd_issue ? rd_bank : bank_q;
      idx_d   = rd_issue ? rd_idx  : idx_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         bank_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         valid_q <= valid_d;
         bank_q  <= bank_d;
         idx_q   <= idx_d;
      end
   end

   // Outputs are forced low while reset is asserted, before the first reset edge settles the flops.
   always_comb begin
      lb_we    = valid_q && !rst;
      lb_addr  = lb_we ? {bank_q, idx_q} : '0;
      lb_wdata = lb_we ? mem_rdata : '0;
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer SRAM between display line prefetch and host writes.
// Latency: reads issue the cycle after line_start; line buffer write 1 cycle after each read; host write same cycle.
// Backpressure: host waits (host_ready=0) during fetch bursts, gets one slot per BURST_LEN reads; line_start beats host.
// Ports: line_start/line_y from VGA timing; host_valid/host_ready/host_addr/host_wdata host write port;
//        mem_* single-port SRAM; lb_* ping-pong line buffer; busy, sticky underrun status.
// Optional: define VGA_FB_STATS_EN to add saturating underrun_cnt and host_stall_cnt outputs.
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int ADDR_W    = FB_ADDR_W,
   parameter int DATA_W    = FB_DATA_W,
   parameter int BURST_LEN = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 line_start,
   input  logic [9:0]           line_y,
   input  logic                 host_valid,
   output logic                 host_ready,
   input  logic [ADDR_W-1:0]    host_addr,
   input  logic [DATA_W-1:0]    host_wdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 lb_we,
   output logic [LB_ADDR_W-1:0] lb_addr,
   output logic [DATA_W-1:0]    lb_wdata,
   output logic                 busy,
`ifdef VGA_FB_STATS_EN
   output logic [15:0]          underrun_cnt,
   output logic [15:0]          host_stall_cnt,
`endif
   output logic                 underrun
);

   localparam int                  BURST_W   = $clog2(BURST_LEN + 1);
   localparam logic [BURST_W-1:0]  BURST_MAX = BURST_W'(BURST_LEN);
   localparam logic [LB_IDX_W-1:0] IDX_LAST  = LB_IDX_W'(H_RES - 1);
   localparam logic [9:0]          V_LIMIT   = 10'(V_RES);

   fb_state_e           state_q, state_d;
   logic [LB_IDX_W-1:0] idx_q, idx_d;
   logic [BURST_W-1:0]  burst_q, burst_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                bank_q, bank_d;
   logic                underrun_q, underrun_d;

   logic                burst_inc;
   logic [BURST_W-1:0]  burst_nxt;
   logic                line_ok;
   logic                abort;
   logic                host_grant;
   logic                rd_fetch;
   logic                rd_issue;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      burst_d    = burst_q;
      base_d     = base_q;
      bank_d     = bank_q;
      underrun_d = underrun_q;
      host_grant = 1'b0;
      rd_fetch   = 1'b0;
      burst_inc  = (burst_q != BURST_MAX);
      burst_nxt  = burst_inc ? burst_q + 1'b1 : burst_q;
      line_ok    = line_start && (line_y < V_LIMIT);
      abort      = line_start && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            host_grant = host_valid && !line_start;
         end
         FETCH: begin
            rd_fetch = 1'b1;
            idx_d    = idx_q + 1'b1;
            burst_d  = burst_nxt;
            // Last read of the line ends the fetch; no host slot is wasted after it.
            if (idx_q == IDX_LAST) begin
               state_d = IDLE;
            end else if (burst_nxt == BURST_MAX && host_valid) begin
               state_d = HOST_SLOT;
            end
         end
         HOST_SLOT: begin
            host_grant = host_valid && !line_start;
            burst_d    = '0;
            state_d    = FETCH;
         end
         default: state_d = IDLE;
      endcase

      // A new line always wins: the old line's remaining reads are dropped.
      if (abort) begin
         underrun_d = 1'b1;
         state_d    = IDLE;
      end
      if (line_ok) begin
         state_d = FETCH;
         base_d  = ADDR_W'(32'(line_y) * 32'(H_RES));
         bank_d  = line_y[0];
         idx_d   = '0;
         burst_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         burst_q    <= '0;
         base_q     <= '0;
         bank_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         burst_q    <= burst_d;
         base_q     <= base_d;
         bank_q     <= bank_d;
         underrun_q <= underrun_d;
      end
   end

   // SRAM and handshake outputs; everything is held low while reset is asserted.
   always_comb begin
      host_ready = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      rd_issue   = rd_fetch && !rst;
      if (!rst) begin
         if (rd_fetch) begin
            mem_en   = 1'b1;
            mem_addr = base_q + ADDR_W'(idx_q);
         end else if (host_grant) begin
            host_ready = 1'b1;
            mem_en     = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
         end
      end
   end

   vga_fb_rd_pipe #(
      .DATA_W (DATA_W)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .rd_issue  (rd_issue),
      .rd_bank   (bank_q),
      .rd_idx    (idx_q),
      .mem_rdata (mem_rdata),
      .lb_we     (lb_we),
      .lb_addr   (lb_addr),
      .lb_wdata  (lb_wdata)
   );

   // busy covers the fetch itself plus the trailing line buffer write.
   assign busy     = !rst && ((state_q != IDLE) || lb_we);
   assign underrun = underrun_q;

`ifdef VGA_FB_STATS_EN
   logic [15:0] underrun_cnt_q, underrun_cnt_d;
   logic [15:0] host_stall_cnt_q, host_stall_cnt_d;

   always_comb begin
      underrun_cnt_d   = underrun_cnt_q;
      host_stall_cnt_d = host_stall_cnt_q;
      if (abort && underrun_cnt_q != 16'hFFFF) begin
         underrun_cnt_d = underrun_cnt_q + 16'd1;
      end
      if (host_valid && !host_ready && host_stall_cnt_q != 16'hFFFF) begin
         host_stall_cnt_d = host_stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_cnt_q   <= '0;
         host_stall_cnt_q <= '0;
      end else begin
         underrun_cnt_q   <= underrun_cnt_d;
         host_stall_cnt_q <= host_stall_cnt_d;
      end
   end

   assign underrun_cnt   = underrun_cnt_q;
   assign host_stall_cnt = host_stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed self-checking bench for vga_fb_arbiter.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Backpressure: host_valid is driven directly; mem_rdata carries a per-cycle tag.
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        line_start;
   logic [9:0]  line_y;
   logic        host_valid;
   logic        host_ready;
   logic [18:0] host_addr;
   logic [23:0] host_wdata;
   logic        mem_en;
   logic        mem_we;
   logic [18:0] mem_addr;
   logic [23:0] mem_wdata;
   logic [23:0] mem_rdata;
   logic        lb_we;
   logic [10:0] lb_addr;
   logic [23:0] lb_wdata;
   logic        busy;
   logic        underrun;
`ifdef VGA_FB_STATS_EN
   logic [15:0] underrun_cnt;
   logic [15:0] host_stall_cnt;
`endif

   int vecs = 0;
   int miscompares = 0;
   int cyc = 0;
   int reads, slots, first_rd, last_rd, first_slot, n, nbusy;

   always #5 clk = ~clk;

   vga_fb_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .line_start     (line_start),
      .line_y         (line_y),
      .host_valid     (host_valid),
      .host_ready     (host_ready),
      .host_addr      (host_addr),
      .host_wdata     (host_wdata),
      .mem_en         (mem_en),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .lb_we          (lb_we),
      .lb_addr        (lb_addr),
      .lb_wdata       (lb_wdata),
      .busy           (busy),
`ifdef VGA_FB_STATS_EN
      .underrun_cnt   (underrun_cnt),
      .host_stall_cnt (host_stall_cnt),
`endif
      .underrun       (underrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1ns after the next rising edge; mem_rdata carries the cycle tag.
   task automatic nxt();
      @(posedge clk);
      #1;
      cyc++;
      mem_rdata = 24'hC00000 | 24'(cyc);
   endtask

   initial begin
      rst = 1'b1; line_start = 1'b0; line_y = '0; host_valid = 1'b1;
      host_addr = 19'h00010; host_wdata = 24'hABCDEF; mem_rdata = '0;

      // Reset with host_valid high
      nxt(); nxt(); #1;
      chk("rst_host_ready", host_ready, 0);
      chk("rst_mem_en",     mem_en,     0);
      chk("rst_mem_addr",   mem_addr,   0);
      chk("rst_lb_we",      lb_we,      0);
      chk("rst_busy",       busy,       0);
      chk("rst_underrun",   underrun,   0);

      // Idle host write
      nxt(); rst = 1'b0; #1;
      chk("idle_host_ready", host_ready, 1);
      chk("idle_mem_en",     mem_en,     1);
      chk("idle_mem_we",     mem_we,     1);
      chk("idle_mem_addr",   mem_addr,   19'h00010);
      chk("idle_mem_wdata",  mem_wdata,  24'hABCDEF);
`ifdef VGA_FB_STATS_EN
      chk("idle_stall_cnt",  host_stall_cnt, 0);
`endif

      // Line 3 fetch, no host traffic
      nxt(); host_valid = 1'b0; line_start = 1'b1; line_y = 10'd3; cyc = 0; #1;
      chk("f3_ls_busy", busy, 0);
      reads = 0; first_rd = -1; last_rd = -1;
      repeat (642) begin
         nxt(); line_start = 1'b0; #1;
         if (mem_en && !mem_we) begin
            reads++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
         end
         if (cyc == 1) begin
            chk("f3_first_addr", mem_addr, 1920);
            chk("f3_busy_rise",  busy, 1);
         end
         if (cyc == 2) begin
            chk("f3_lb_we_first",  lb_we, 1);
            chk("f3_lb_addr_first", lb_addr, 11'h400);
            chk("f3_lb_wdata",      lb_wdata, 24'hC00002);
         end
         if (cyc == 640) chk("f3_last_addr", mem_addr, 2559);
         if (cyc == 641) begin
            chk("f3_lb_addr_last", lb_addr, 11'h67F);
            chk("f3_busy_641",     busy, 1);
         end
         if (cyc == 642) begin
            chk("f3_busy_fall", busy, 0);
            chk("f3_lb_we_off", lb_we, 0);
         end
      end
      chk("f3_reads",    reads, 640);
      chk("f3_first_rd", first_rd, 1);
      chk("f3_last_rd",  last_rd, 640);

      // Line 0 fetch with host_valid held high
      nxt(); line_start = 1'b1; line_y = 10'd0; host_valid = 1'b1;
      host_addr = 19'h70000; host_wdata = 24'h123456; cyc = 0; #1;
      chk("arb_ls_priority", host_ready, 0);
      reads = 0; slots = 0; last_rd = -1; first_slot = -1;
      repeat (679) begin
         nxt(); line_start = 1'b0; #1;
         if (mem_en && !mem_we) begin
            reads++;
            last_rd = cyc;
         end
         if (host_ready) begin
            slots++;
            if (first_slot < 0) begin
               first_slot = cyc;
               chk("arb_slot_we",   mem_we, 1);
               chk("arb_slot_addr", mem_addr, 19'h70000);
            end
         end
      end
      chk("arb_reads",      reads, 640);
      chk("arb_slots",      slots, 39);
      chk("arb_first_slot", first_slot, 17);
      chk("arb_last_rd",    last_rd, 679);
      nxt(); #1;
      chk("arb_idle_ready", host_ready, 1);
`ifdef VGA_FB_STATS_EN
      chk("arb_stall_cnt", host_stall_cnt, 641);
`endif
      host_valid = 1'b0;
      repeat (4) nxt();

      // Overrun: line 5 arrives at cycle 100 while line 4 is fetching
      nxt(); line_start = 1'b1; line_y = 10'd4; cyc = 0; #1;
      repeat (99) begin
         nxt(); line_start = 1'b0; #1;
      end
      chk("ovr_addr_99", mem_addr, 2658);
      nxt(); line_start = 1'b1; line_y = 10'd5; #1;
      chk("ovr_lb_we_100",   lb_we, 1);
      chk("ovr_lb_addr_100", lb_addr, 11'h062);
      chk("ovr_underrun_100", underrun, 0);
      nxt(); line_start = 1'b0; #1;
      chk("ovr_underrun_101", underrun, 1);
      chk("ovr_addr_101",     mem_addr, 3200);
      nxt(); #1;
      chk("ovr_lb_addr_102", lb_addr, 11'h400);
      n = 0;
      while (busy && n < 2000) begin
         nxt(); #1;
         n++;
      end
      chk("ovr_done_busy", busy, 0);
      chk("ovr_sticky",    underrun, 1);
`ifdef VGA_FB_STATS_EN
      chk("ovr_underrun_cnt", underrun_cnt, 1);
`endif

      // Blank line: no reads, busy stays low
      nxt(); line_start = 1'b1; line_y = 10'd480; #1;
      chk("blank_ls_mem_en", mem_en, 0);
      n = 0; nbusy = 0;
      repeat (20) begin
         nxt(); line_start = 1'b0; #1;
         if (mem_en) n++;
         if (busy) nbusy++;
      end
      chk("blank_reads", n, 0);
      chk("blank_busy",  nbusy, 0);
      chk("blank_underrun_kept", underrun, 1);

      // Only reset clears underrun
      nxt(); rst = 1'b1;
      nxt(); rst = 1'b0; #1;
      chk("rst_clears_underrun", underrun, 0);
`ifdef VGA_FB_STATS_EN
      chk("rst_clears_cnt", underrun_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer SRAM between two requesters:
  - Display line prefetch, which fills a ping-pong line buffer ahead of each active line. This requester is deadline-driven.
  - A host write port using a valid/ready handshake.
- Sits between the VGA timing generator (line_start/line_y strobes) and the SRAM and line buffer.
- The display side drains the line buffer during the following active line.

Parameters:
- H_RES, 640, words fetched per line
- V_RES, 480, active lines; line_y >= V_RES is never fetched
- ADDR_W, 19, SRAM word address width
- DATA_W, 24, pixel word width (8:8:8 RGB)
- BURST_LEN, 16, fetch reads issued back-to-back before one host slot is offered

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- line_start  in  1  one-cycle pulse: begin fetching line line_y
- line_y  in  10  line to fetch, sampled with line_start
- host_valid  in  1  host write request
- host_ready  out  1  host write accepted this cycle (valid && ready)
- host_addr  in  ADDR_W  host write address
- host_wdata  in  DATA_W  host write data
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after a read
- lb_we  out  1  line buffer write enable
- lb_addr  out  11  {bank, index[9:0]}; bank = fetched line_y[0]
- lb_wdata  out  DATA_W  line buffer write data
- busy  out  1  fetch in progress
- underrun  out  1  sticky: a fetch was aborted by a new line_start

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0; underrun cleared. Reset mid-fetch abandons the fetch immediately.
- FSM states: IDLE, FETCH, HOST_SLOT.
- IDLE:
  - line_start with line_y < V_RES: latch base = line_y*H_RES (truncated to ADDR_W), latch bank = line_y[0], idx = 0, go to FETCH.
  - line_start with line_y >= V_RES: ignored.
  - Otherwise, a host write is served every cycle host_valid is high.
- FETCH:
  - Each cycle: mem_en=1, mem_we=0, mem_addr=base+idx; idx and burst counter increment.
  - When the burst count reaches BURST_LEN, or idx reaches H_RES-1, go to HOST_SLOT, but only if host_valid is high and idx < H_RES-1. Otherwise stay in FETCH.
  - On the last read (idx = H_RES-1), go to IDLE.
- HOST_SLOT:
  - Exactly one cycle: if host_valid, host_ready=1, mem_en=1, mem_we=1, address and data from the host.
  - Burst counter clears; return to FETCH.
- host_ready:
  - Combinational: high only in IDLE or HOST_SLOT while host_valid is high and no line_start is present this cycle.
  - line_start has priority over the host in IDLE.
- Read return:
  - A read issued in cycle t produces lb_we=1 at cycle t+1, with lb_addr={bank, idx_t} and lb_wdata=mem_rdata.
  - The returning read pipeline completes even after the FSM leaves FETCH.
- busy: 1 from the cycle after the accepting line_start through the last lb_we.
- Overlap:
  - line_start while in FETCH/HOST_SLOT: set underrun, drop the remaining reads of the old line, restart on the new line.
  - The in-flight read of the old line still writes its old bank and index.
- underrun clears only on rst.
- Fetch cost with no host traffic: line_start at cycle 0 -> reads at cycles 1..H_RES -> last lb_we at cycle H_RES+1.

Optional Feature:
- VGA_FB_STATS_EN defined: adds output underrun_cnt[15:0].
  - Saturating count of aborted fetches.
  - Adds output host_stall_cnt[15:0]: saturating count of cycles with host_valid=1 and host_ready=0.
  - Both reset to 0.
- VGA_FB_STATS_EN undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package vga_fb_pkg:
  - FSM state encoding (IDLE=0, FETCH=1, HOST_SLOT=2).
  - Default widths (ADDR_W, DATA_W, LB_ADDR_W=11).
- One sub-module, vga_fb_rd_pipe: the 1-cycle read-return register (valid, bank, index). It turns issued reads into lb_we/lb_addr/lb_wdata independently of FSM state.

Test Plan:
- Reset: rst=1 for 2 cycles with host_valid=1 -> all outputs 0, host_ready=0, underrun=0.
- Idle host writes: host_valid=1, addr=0x00010, data=0xABCDEF -> same cycle mem_en=1, mem_we=1, mem_addr=0x00010, host_ready=1.
- Line fetch, no host traffic:
  - Stimulus: line_start with line_y=3.
  - Reads: first mem_addr=1920 at cycle 1, last mem_addr=2559 at cycle 640.
  - Line buffer: lb_addr=0x400..0x67F at cycles 2..641.
  - busy falls at cycle 642.
- Arbitration: host_valid held high during the fetch of line 0 -> reads issued in 16-cycle bursts; host_ready=1 for one cycle after each burst; 39 host slots in total; last read at cycle 679.
- Overrun: second line_start (line_y=5) at cycle 100 during the fetch of line 4 -> underrun=1; cycle 101 mem_addr=3200; read from cycle 99 still writes lb_addr=0x062.
- Blank lines: line_start with line_y=480 -> no mem reads, busy stays 0. With VGA_FB_STATS_EN, the overrun case -> underrun_cnt=1.
